// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sub-word loads with extension, read-modify-write
// sub-word stores, and single-cycle error completion for illegal or misaligned requests.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);
  localparam int LANES = 4;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, FIN} state_t;
  state_t state, state_nxt;

  logic        store_q, sext_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        req_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val, ins, merged;
  logic [LANES-1:0] be;

  assign req_bad = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign busy     = (state != IDLE);

  // Load lane selection and extension
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      2'b11:   ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Store data replicated across lanes; byte enables pick which lanes replace the captured word
  always_comb begin
    ins = size_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    if (size_q[0]) be = addr_q[1] ? 4'b1100 : 4'b0011;
    else           be = 4'b0001 << addr_q[1:0];
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*8 +: 8] = be[i] ? ins[i*8 +: 8] : word_q[i*8 +: 8];
  end

  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (req_bad)            state_nxt = FIN;
        else if (!is_store)     state_nxt = RD;
        else if (size == 2'b10) state_nxt = WR;
        else                    state_nxt = RMW_RD;
      end
      RD: begin
        mem_re = 1'b1;
        if (mem_ready) state_nxt = FIN;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
        if (mem_ready) state_nxt = FIN;
      end
      RMW_RD: begin
        mem_re = 1'b1;
        if (mem_ready) state_nxt = RMW_WR;
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        if (mem_ready) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      store_q <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        store_q <= is_store;
        sext_q  <= sign_ext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= req_bad;
      end
      if (state == RMW_RD && mem_ready) word_q <= mem_rdata;
      if (state == RD && mem_ready && !store_q) rdata <= ld_val;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a word memory with programmable wait states,
// expected completions and writes queued at issue time and checked as the DUT produces them.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_store = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic        mem_re, mem_we, mem_ready, busy, done, err;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [31:0] rdata; int lat; int n_rd; int n_wr; int t0; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [31:0] mem [0:1023];
  logic [31:0] exp_rdata = '0;
  int vecs = 0, errs = 0;
  int cyc = 0, wcnt = 0, wait_n = 0;
  int done_cnt = 0, rd_hs = 0, wr_hs = 0, str_cyc = 0;
  logic s_str = 1'b0, s_rdy = 1'b0;

  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = (mem_re | mem_we) && (wcnt >= wait_n);

  always @(posedge clk) cyc <= cyc + 1;

  // Wait-state counter: counts cycles a strobe has been pending without ready
  always @(posedge clk or posedge rst) begin
    if (rst)                 wcnt <= 0;
    else if (s_str && !s_rdy) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    wr_t  w;
    @(negedge clk);
    if (mem_re | mem_we) str_cyc++;
    if (mem_re && mem_ready) rd_hs++;
    if (mem_we && mem_ready) begin
      wr_hs++;
      if (wr_q.size() == 0) chk("spurious_wr", wr_q.size(), 1);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("spurious_done", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("err", err, e.err);
        chk("rdata", rdata, e.rdata);
        chk("latency", cyc - e.t0, e.lat);
        chk("n_rd", rd_hs, e.n_rd);
        chk("n_wr", wr_hs, e.n_wr);
      end
      rd_hs = 0;
      wr_hs = 0;
    end
    s_str = mem_re | mem_we;
    s_rdy = mem_ready;
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int w, input bit poke);
    exp_t e;
    wr_t  wq;
    logic [31:0] word, sh8, sh16, mask, ins;
    logic bad;
    int d0;
    word = mem[a[11:2]];
    sh8  = word >> {a[1:0], 3'b000};
    sh16 = word >> {a[1], 4'b0000};
    bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    e.err = bad; e.n_rd = 0; e.n_wr = 0;
    if (bad) e.lat = 1;
    else if (!st) begin
      case (sz)
        2'd0:    exp_rdata = sx ? {{24{sh8[7]}}, sh8[7:0]} : {24'h0, sh8[7:0]};
        2'd1:    exp_rdata = sx ? {{16{sh16[15]}}, sh16[15:0]} : {16'h0, sh16[15:0]};
        default: exp_rdata = word;
      endcase
      e.lat = 2 + w; e.n_rd = 1;
    end else if (sz == 2'd2) begin
      wq.addr = {a[31:2], 2'b00}; wq.data = wd; wr_q.push_back(wq);
      e.lat = 2 + w; e.n_wr = 1;
    end else begin
      mask = (sz == 2'd0) ? (32'hFF << {a[1:0], 3'b000}) : (32'hFFFF << {a[1], 4'b0000});
      ins  = (sz == 2'd0) ? ({24'h0, wd[7:0]} << {a[1:0], 3'b000})
                          : ({16'h0, wd[15:0]} << {a[1], 4'b0000});
      wq.addr = {a[31:2], 2'b00}; wq.data = (word & ~mask) | (ins & mask); wr_q.push_back(wq);
      e.lat = 3 + 2 * w; e.n_rd = 1; e.n_wr = 1;
    end
    e.rdata = exp_rdata;
    wait_n = w;
    is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd; start = 1'b1;
    e.t0 = cyc;
    exp_q.push_back(e);
    d0 = done_cnt;
    tick();
    start = 1'b0;
    if (poke) begin
      tick();
      is_store = 1'b1; size = 2'd2; addr = 32'h600; wdata = 32'hDEAD_BEEF; start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
    repeat (2) tick();
    chk("one_done", done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    logic [1:0]  rsz;
    logic [31:0] ra;
    for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5C3_0F96;
    mem[32'h100 >> 2] = 32'h8001_1234;
    mem[32'h10C >> 2] = 32'hCAFE_F00D;
    mem[32'h200 >> 2] = 32'hAB00_0000;
    mem[32'h204 >> 2] = 32'h0080_7F11;
    mem[32'h300 >> 2] = 32'h1122_3344;
    mem[32'h310 >> 2] = 32'h5566_7788;

    repeat (2) tick();
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    rst = 1'b0;
    tick();

    do_req(0, 2'd1, 1, 32'h102, 32'h0, 0, 0);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    do_req(0, 2'd0, 0, 32'h203, 32'h0, 0, 0);
    chk("lbu_rdata", rdata, 32'h0000_00AB);
    do_req(1, 2'd1, 0, 32'h300, 32'h0000_BEEF, 0, 0);
    do_req(0, 2'd2, 0, 32'h401, 32'h0, 0, 0);
    chk("misalign_rdata", rdata, 32'h0000_00AB);
    do_req(1, 2'd3, 0, 32'h010, 32'h1234_5678, 0, 0);
    do_req(1, 2'd1, 0, 32'h305, 32'h1234_5678, 0, 0);
    do_req(0, 2'd2, 0, 32'h10C, 32'h0, 2, 0);
    do_req(1, 2'd0, 0, 32'h311, 32'h1234_5677, 1, 0);
    do_req(1, 2'd2, 0, 32'h320, 32'h0BAD_CAFE, 0, 0);
    do_req(0, 2'd1, 0, 32'h106, 32'h0, 1, 0);
    do_req(0, 2'd0, 1, 32'h206, 32'h0, 0, 0);
    do_req(0, 2'd0, 1, 32'h205, 32'h0, 0, 0);
    do_req(0, 2'd2, 0, 32'h104, 32'h0, 3, 1);

    for (int n = 0; n < 24; n++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) ra = (rsz == 2'd2) ? {ra[31:2], 2'b00} : (rsz == 2'd1) ? {ra[31:1], 1'b0} : ra;
      do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 2), 0);
    end

    // Abort a stalled load with reset mid-wait
    wait_n = 5;
    d0 = done_cnt;
    is_store = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h500; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("wait_re", mem_re, 1);
      chk("wait_addr", mem_addr, 32'h500);
      chk("wait_rdy", mem_ready, 0);
      if (i == 0) tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_re", mem_re, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata, 0);
    exp_rdata = '0;
    tick();
    rst = 1'b0;
    str_cyc = 0; rd_hs = 0; wr_hs = 0;
    repeat (6) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_strobe", str_cyc, 0);

    do_req(0, 2'd1, 1, 32'h102, 32'h0, 0, 0);
    chk("post_rst_rdata", rdata, 32'hFFFF_8001);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning; clock and reset are listed first.
REQ-002 clk  in  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  request strobe; sampled only in IDLE.
REQ-005 is_store  in  1  request type: 1 = store, 0 = load.
REQ-006 size  in  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is illegal.
REQ-007 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  in  32  byte address of the access.
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 mem_addr  out  32  word-aligned memory address.
REQ-011 mem_re  out  1  memory read request.
REQ-012 mem_we  out  1  memory write request.
REQ-013 mem_wdata  out  32  full word written to memory.
REQ-014 mem_rdata  in  32  memory read word; valid when mem_ready is high during a read.
REQ-015 mem_ready  in  1  memory completion for the current mem_re or mem_we.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  misalignment or illegal-size flag; valid only with done.
REQ-019 rdata  out  32  extended load result; held until the next load completes.

Function
REQ-020 States SHALL be IDLE, RD, WR, RMW_RD, RMW_WR and FIN.
REQ-021 On a request:
- In IDLE with start=1, the block SHALL latch is_store, size, sign_ext, addr and wdata.
- start SHALL be ignored in every other state.
REQ-022 Error conditions:
- Illegal size (11) or misalignment (halfword with addr[0]=1; word with addr[1:0]≠00) SHALL go IDLE→FIN with err=1.
- No mem_re or mem_we SHALL be issued for such a request.
REQ-023 Legal requests SHALL transition from IDLE as follows:
- load → RD
- word store → WR
- byte or halfword store → RMW_RD
REQ-024 mem_addr SHALL equal {addr_q[31:2],2'b00} and be held constant in RD, WR, RMW_RD and RMW_WR.
REQ-025 Memory strobes:
- mem_re SHALL be high exactly in RD and RMW_RD.
- mem_we SHALL be high exactly in WR and RMW_WR.
- Each strobe SHALL hold until mem_ready=1.
REQ-026 Transitions on mem_ready=1:
- RD→FIN
- WR→FIN
- RMW_RD→RMW_WR, capturing mem_rdata into an internal word register.
REQ-027 Load extraction in RD on mem_ready:
- Halfword: mem_rdata[15:0] when addr_q[1]=0, else [31:16].
- Byte: lane addr_q[1:0] (00 = bits 7:0, …, 11 = bits 31:24).
- Extension: sign_ext selects sign- or zero-extension to 32 bits.
- Word: passed unchanged.
- rdata SHALL be registered in the same edge that enters FIN.
REQ-028 RMW merge: in RMW_WR, mem_wdata SHALL equal the captured word with only the addressed byte or halfword lane replaced by wdata_q[7:0] or wdata_q[15:0].
REQ-029 In WR, mem_wdata SHALL equal wdata_q.
REQ-030 FIN:
- done=1 for exactly one cycle.
- err SHALL be 1 only for an error request.
- The next state is unconditionally IDLE.
REQ-031 Minimum latency from the start edge to the done pulse, with mem_ready tied high:
- Load or word store: 2 cycles.
- Sub-word store: 3 cycles.
- Error: 1 cycle.
REQ-032 An erroring load SHALL leave rdata unchanged.

Reset
REQ-033 On rst=1, the block SHALL immediately enter IDLE, including mid-access; no further strobes are issued for an aborted request.
REQ-034 Reset values:
- mem_re=0, mem_we=0, busy=0, done=0, err=0.
- rdata=0, mem_addr=0, mem_wdata=0.
- All latched request registers = 0.

Verification
REQ-035 Load halfword:
- Stimulus: addr=0x102, size=01, sign_ext=1; memory returns 0x8001_1234 with ready in the first cycle.
- Required response: mem_addr=0x100, rdata=0xFFFF_8001, done 2 cycles after start.
REQ-036 Load byte:
- Stimulus: addr=0x203, size=00, sign_ext=0; memory returns 0xAB00_0000.
- Required response: rdata=0x0000_00AB, err=0.
REQ-037 Store halfword:
- Stimulus: addr=0x300, size=01, wdata=0x0000_BEEF; memory word is 0x1122_3344.
- Required response: one read, then one write with mem_wdata=0x1122_BEEF; done 3 cycles after start.
REQ-038 Misaligned word load:
- Stimulus: addr=0x401, size=10.
- Required response: no mem_re or mem_we; done=1 and err=1 in the cycle after start; rdata unchanged.
REQ-039 Wait states and reset:
- Stimulus: mem_ready held 0 for 3 cycles in RD.
- Required response: mem_re and mem_addr are stable for those cycles.
- Stimulus: rst asserted during the 2nd wait cycle.
- Required response: mem_re falls asynchronously, busy=0, and no done pulse follows.
REQ-040 Busy lock-out:
- Stimulus: start pulsed while busy=1.
- Required response: the pulse is ignored; exactly one done is produced for the original request.
